// File: rtl/branch_pkg.sv
// Shared encodings for the dynamic branch predictor: opcodes, PC mux selects,
// counter reference points and the table sequencing states.
package branch_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [2:0] PCMUX_PC4      = 3'd0;
    localparam logic [2:0] PCMUX_JAL      = 3'd3;
    localparam logic [2:0] PCMUX_JALR     = 3'd4;
    localparam logic [2:0] PCMUX_BR_TAKEN = 3'd5;
    localparam logic [2:0] PCMUX_PRED     = 3'd6;
    localparam logic [2:0] PCMUX_BR_NOT   = 3'd7;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int cnt_weak_nt(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int cnt_weak_t(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int cnt_strong_t(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor storage: counter/valid/tag/target per index, swept clear after reset,
// two combinational read ports (fetch and execute) and one synchronous write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing one entry per cycle, lookups and writes disabled
// ST_RUN  | table live, ready=1
module bp_table
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2,
    parameter int TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic [INDEX_BITS-1:0] rd_idx_f,
    output logic [CNT_BITS-1:0]   rd_cnt_f,
    output logic                  rd_valid_f,
    output logic [TAG_BITS-1:0]   rd_tag_f,
    output logic [XLEN-1:0]       rd_target_f,
    input  logic [INDEX_BITS-1:0] rd_idx_e,
    output logic [CNT_BITS-1:0]   rd_cnt_e,
    output logic                  rd_valid_e,
    output logic [TAG_BITS-1:0]   rd_tag_e,
    input  logic                  wr_en,
    input  logic                  wr_btb,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [CNT_BITS-1:0]   wr_cnt,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [XLEN-1:0]       wr_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cnt_weak_nt(CNT_BITS));

    logic [CNT_BITS-1:0]   cnt_q    [ENTRIES];
    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]       target_q [ENTRIES];
    logic [0:0]            state;
    logic [INDEX_BITS-1:0] init_idx;

    assign ready = (state == ST_RUN);

    assign rd_cnt_f    = cnt_q[rd_idx_f];
    assign rd_valid_f  = valid_q[rd_idx_f];
    assign rd_tag_f    = tag_q[rd_idx_f];
    assign rd_target_f = target_q[rd_idx_f];
    assign rd_cnt_e    = cnt_q[rd_idx_e];
    assign rd_valid_e  = valid_q[rd_idx_e];
    assign rd_tag_e    = tag_q[rd_idx_e];

    // Tag and target are cleared too so compares never see uninitialised data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            cnt_q[init_idx]    <= CNT_INIT;
            valid_q[init_idx]  <= 1'b0;
            tag_q[init_idx]    <= '0;
            target_q[init_idx] <= '0;
            init_idx           <= init_idx + 1'b1;
            if (init_idx == '1)
                state <= ST_RUN;
        end else if (wr_en) begin
            cnt_q[wr_idx] <= wr_cnt;
            if (wr_btb) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch prediction with execute-stage resolution: PC mux priority,
// table training and saturating branch/mispredict statistics.
module dynamic_branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2,
    parameter int TAG_BITS   = 8,
    parameter int STAT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      pcF,
    input  logic [XLEN-1:0]      instF,
    input  logic                 killF,
    input  logic [XLEN-1:0]      instD,
    input  logic                 killD,
    input  logic                 pcmux_sel_F,
    input  logic [XLEN-1:0]      pcE,
    input  logic [XLEN-1:0]      instE,
    input  logic                 killE,
    input  logic                 takenE,
    input  logic [XLEN-1:0]      targetE,
    input  logic                 predtakenE,
    output logic                 predict_taken,
    output logic [XLEN-1:0]      predict_target,
    output logic [2:0]           pcmux_sel_out,
    output logic                 predict_fail,
    output logic                 ready,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int TAG_LO = INDEX_BITS + 2;
    localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'(cnt_weak_nt(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(cnt_weak_t(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX     = CNT_BITS'(cnt_strong_t(CNT_BITS));

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic [CNT_BITS-1:0]   rd_cnt_f, rd_cnt_e, cnt_next;
    logic                  rd_valid_f, rd_valid_e;
    logic [TAG_BITS-1:0]   rd_tag_f, rd_tag_e;
    logic [XLEN-1:0]       rd_target_f;
    logic                  is_b_f, is_jal_f, is_jalr_f, is_jalr_d, is_b_e;
    logic                  hit_f, hit_e, resolve_e;
    logic                  unused_ok;

    assign idx_f = pcF[INDEX_BITS+1:2];
    assign tag_f = pcF[TAG_HI:TAG_LO];
    assign idx_e = pcE[INDEX_BITS+1:2];
    assign tag_e = pcE[TAG_HI:TAG_LO];

    assign is_b_f    = (instF[6:2] == OP_BRANCH);
    assign is_jal_f  = (instF[6:2] == OP_JAL);
    assign is_jalr_f = (instF[6:2] == OP_JALR);
    assign is_jalr_d = (instD[6:2] == OP_JALR);
    assign is_b_e    = (instE[6:2] == OP_BRANCH);

    assign unused_ok = ^{instF[XLEN-1:7], instF[1:0], instD[XLEN-1:7], instD[1:0],
                         instE[XLEN-1:7], instE[1:0], pcF[XLEN-1:TAG_HI+1], pcF[1:0],
                         pcE[XLEN-1:TAG_HI+1], pcE[1:0]};

    bp_table #(
        .XLEN       (XLEN),
        .INDEX_BITS (INDEX_BITS),
        .CNT_BITS   (CNT_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .rd_idx_f    (idx_f),
        .rd_cnt_f    (rd_cnt_f),
        .rd_valid_f  (rd_valid_f),
        .rd_tag_f    (rd_tag_f),
        .rd_target_f (rd_target_f),
        .rd_idx_e    (idx_e),
        .rd_cnt_e    (rd_cnt_e),
        .rd_valid_e  (rd_valid_e),
        .rd_tag_e    (rd_tag_e),
        .wr_en       (resolve_e),
        .wr_btb      (resolve_e & takenE),
        .wr_idx      (idx_e),
        .wr_cnt      (cnt_next),
        .wr_tag      (tag_e),
        .wr_target   (targetE)
    );

    assign hit_f          = rd_valid_f & (rd_tag_f == tag_f);
    assign predict_taken  = ready & hit_f & rd_cnt_f[CNT_BITS-1] & is_b_f & !killF;
    assign predict_target = ready ? rd_target_f : '0;

    assign resolve_e    = ready & !killE & is_b_e;
    assign predict_fail = resolve_e & (takenE != predtakenE);

    always_comb begin
        pcmux_sel_out = PCMUX_PC4;
        if (!ready) begin
            if (is_b_f)
                pcmux_sel_out = PCMUX_PC4;
            else if (is_jal_f)
                pcmux_sel_out = PCMUX_JAL;
            else
                pcmux_sel_out = {2'b00, pcmux_sel_F};
        end else if (predict_fail) begin
            pcmux_sel_out = takenE ? PCMUX_BR_TAKEN : PCMUX_BR_NOT;
        end else if (!killD && is_jalr_d) begin
            pcmux_sel_out = PCMUX_JALR;
        end else if (!killF) begin
            if (is_b_f)
                pcmux_sel_out = predict_taken ? PCMUX_PRED : PCMUX_PC4;
            else if (is_jal_f)
                pcmux_sel_out = PCMUX_JAL;
            else if (is_jalr_f)
                pcmux_sel_out = PCMUX_PC4;
            else
                pcmux_sel_out = {2'b00, pcmux_sel_F};
        end
    end

    // An entry owned by another branch restarts from the weak state rather than stepping.
    assign hit_e = rd_valid_e & (rd_tag_e == tag_e);

    always_comb begin
        cnt_next = rd_cnt_e;
        if (!hit_e)
            cnt_next = takenE ? CNT_WEAK_T : CNT_WEAK_NT;
        else if (takenE)
            cnt_next = (rd_cnt_e == CNT_MAX) ? rd_cnt_e : rd_cnt_e + 1'b1;
        else
            cnt_next = (rd_cnt_e == '0) ? rd_cnt_e : rd_cnt_e - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve_e && stat_branches != '1)
                stat_branches <= stat_branches + 1'b1;
            if (predict_fail && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue that a
// negedge monitor pops and compares against the predictor outputs.
module tb_dynamic_branch_predictor;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BR    = 32'h0000_0063;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] JALR  = 32'h0000_0067;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pcF, instF, instD, pcE, instE, targetE;
    logic        killF, killD, pcmux_sel_F, killE, takenE, predtakenE;
    logic        predict_taken, predict_fail, ready;
    logic [31:0] predict_target, stat_branches, stat_mispredicts;
    logic [2:0]  pcmux_sel_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        pt;
        logic [31:0] tgt;
        bit          chk_tgt;
        logic        fail;
        logic        rdy;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];

    dynamic_branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pcF              (pcF),
        .instF            (instF),
        .killF            (killF),
        .instD            (instD),
        .killD            (killD),
        .pcmux_sel_F      (pcmux_sel_F),
        .pcE              (pcE),
        .instE            (instE),
        .killE            (killE),
        .takenE           (takenE),
        .targetE          (targetE),
        .predtakenE       (predtakenE),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .pcmux_sel_out    (pcmux_sel_out),
        .predict_fail     (predict_fail),
        .ready            (ready),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", name, field, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "sel", {29'd0, pcmux_sel_out}, {29'd0, e.sel});
                cmp(e.name, "predict_taken", {31'd0, predict_taken}, {31'd0, e.pt});
                if (e.chk_tgt)
                    cmp(e.name, "predict_target", predict_target, e.tgt);
                cmp(e.name, "predict_fail", {31'd0, predict_fail}, {31'd0, e.fail});
                cmp(e.name, "ready", {31'd0, ready}, {31'd0, e.rdy});
                cmp(e.name, "stat_branches", stat_branches, e.sb);
                cmp(e.name, "stat_mispredicts", stat_mispredicts, e.sm);
            end
        end
    end

    task automatic expect_out(input string name, input logic [2:0] sel, input logic pt,
                              input logic [31:0] tgt, input bit chk_tgt, input logic fail,
                              input logic rdy, input logic [31:0] sb, input logic [31:0] sm);
        exp_t e;
        e.name = name; e.sel = sel; e.pt = pt; e.tgt = tgt; e.chk_tgt = chk_tgt;
        e.fail = fail; e.rdy = rdy; e.sb = sb; e.sm = sm;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        pcF = '0; instF = NOP; killF = 0; instD = NOP; killD = 0; pcmux_sel_F = 0;
        pcE = '0; instE = NOP; killE = 0; takenE = 0; targetE = '0; predtakenE = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic e_branch(input logic [31:0] pc, input logic tk, input logic ptk,
                            input logic [31:0] tgt);
        instE = BR; pcE = pc; takenE = tk; predtakenE = ptk; targetE = tgt;
    endtask

    task automatic f_branch(input logic [31:0] pc);
        instF = BR; pcF = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Restarted sweep: ready must rise on the 64th edge after this release.
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (i == 10) begin
                instF = JAL;
                expect_out("init_jal", 3'd3, 0, 32'h0, 1, 0, 0, 0, 0);
            end else if (i == 20) begin
                pcmux_sel_F = 1;
                expect_out("init_default", 3'd1, 0, 32'h0, 1, 0, 0, 0, 0);
            end else if (i == 63) begin
                f_branch(32'h100);
                e_branch(32'h100, 1, 0, 32'h80);
                expect_out("init_last", 3'd0, 0, 32'h0, 1, 0, 0, 0, 0);
            end else if (i == 64) begin
                expect_out("ready_rise", 3'd0, 0, 32'h0, 0, 0, 1, 0, 0);
            end
        end

        cyc(); e_branch(32'h100, 1, 1, 32'h80); pcmux_sel_F = 1;
        expect_out("train1", 3'd1, 0, 32'h0, 0, 0, 1, 0, 0);
        cyc(); e_branch(32'h100, 1, 1, 32'h80);
        cyc(); f_branch(32'h100);
        expect_out("trained_hit", 3'd6, 1, 32'h80, 1, 0, 1, 2, 0);
        cyc(); e_branch(32'h100, 0, 1, 32'h0);
        expect_out("mis_nt", 3'd7, 0, 32'h0, 0, 1, 1, 2, 0);
        cyc(); e_branch(32'h100, 1, 0, 32'h80);
        expect_out("mis_t", 3'd5, 0, 32'h0, 0, 1, 1, 3, 1);
        cyc(); e_branch(32'h100, 1, 0, 32'h80); killE = 1; instD = JALR; f_branch(32'h100);
        expect_out("jalr_d", 3'd4, 1, 32'h80, 1, 0, 1, 4, 2);
        cyc(); e_branch(32'h100, 1, 0, 32'h80); killE = 1; instD = JALR; killD = 1;
        f_branch(32'h100);
        expect_out("jalr_d_killed", 3'd6, 1, 32'h80, 1, 0, 1, 4, 2);

        for (int i = 0; i < 5; i++) begin
            cyc(); e_branch(32'h204, 1, 1, 32'h300);
            if (i == 4) begin
                f_branch(32'h204);
                expect_out("sat_taken", 3'd6, 1, 32'h300, 1, 0, 1, 8, 2);
            end
        end
        cyc(); e_branch(32'h204, 0, 0, 32'h0); f_branch(32'h204);
        expect_out("sat_nt1_rbw", 3'd6, 1, 32'h300, 1, 0, 1, 9, 2);
        cyc(); f_branch(32'h204);
        expect_out("sat_nt1_after", 3'd6, 1, 32'h300, 1, 0, 1, 10, 2);
        cyc(); e_branch(32'h204, 0, 0, 32'h0); f_branch(32'h204);
        expect_out("sat_nt2_rbw", 3'd6, 1, 32'h300, 1, 0, 1, 10, 2);
        cyc(); f_branch(32'h204);
        expect_out("sat_nt2_after", 3'd0, 0, 32'h0, 0, 0, 1, 11, 2);

        cyc(); f_branch(32'h4100);
        expect_out("alias_miss", 3'd0, 0, 32'h0, 0, 0, 1, 11, 2);
        cyc(); f_branch(32'h100); killF = 1;
        expect_out("killf", 3'd0, 0, 32'h0, 0, 0, 1, 11, 2);
        cyc(); instF = JAL;
        expect_out("jal_f", 3'd3, 0, 32'h0, 0, 0, 1, 11, 2);
        cyc(); instF = JALR; pcmux_sel_F = 1;
        expect_out("jalr_f", 3'd0, 0, 32'h0, 0, 0, 1, 11, 2);
        cyc(); e_branch(32'h4100, 0, 0, 32'h0); f_branch(32'h100);
        expect_out("alias_upd_rbw", 3'd6, 1, 32'h80, 1, 0, 1, 11, 2);
        cyc(); f_branch(32'h100);
        expect_out("alias_reinit", 3'd0, 0, 32'h0, 0, 0, 1, 12, 2);

        cyc();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dynamic_branch_predictor.md
Name: dynamic_branch_predictor

Overview:
Parametrised successor to the static not-taken branch selector in the fetch/branch pipeline. It predicts B-type branches at F using a table of saturating counters indexed by PC bits, plus a tagged branch target buffer (BTB). It resolves each prediction at E, generates predict_fail and the recovery pcmux select, and trains the tables. It also keeps saturating branch and mispredict statistics counters. It sits between the PC mux and the F/D/E pipeline registers.

Parameters:
XLEN, 32, PC and instruction width
INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries (PC[INDEX_BITS+1:2])
CNT_BITS, 2, saturating counter width
TAG_BITS, 8, BTB tag width (PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2])
STAT_BITS, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
pcF  in  XLEN  fetch PC
instF  in  XLEN  fetched instruction
killF  in  1  F slot squashed
instD  in  XLEN  decode instruction
killD  in  1  D slot squashed
pcmux_sel_F  in  1  default F select bit (non-control-flow)
pcE  in  XLEN  execute PC
instE  in  XLEN  execute instruction
killE  in  1  E slot squashed
takenE  in  1  branch outcome resolved at E
targetE  in  XLEN  resolved branch target
predtakenE  in  1  prediction carried down the pipe with the instruction in E
predict_taken  out  1  F prediction, to be piped to E
predict_target  out  XLEN  BTB target for the F branch
pcmux_sel_out  out  3  PC mux select
predict_fail  out  1  flush F/D
ready  out  1  table initialisation complete
stat_branches  out  STAT_BITS  resolved branches
stat_mispredicts  out  STAT_BITS  mispredicted branches

Behaviour:
- Opcodes (instX[6:2]): B=11000, JAL=11011, JALR=11001.
- pcmux_sel encoding: 0 PC+4; 3 JAL; 4 JALR; 5 taken-branch recovery (targetE); 6 predicted target (predict_target); 7 not-taken recovery (pcE+4).
- Table entry fields: counter[CNT_BITS], valid, tag[TAG_BITS], target[XLEN].
- FSM states:
  - INIT: entered when rst_n=0. Index counter starts at 0 and clears one entry per cycle (counter = weakly-not-taken 2^(CNT_BITS-1)-1, valid=0). Leaves after the last index, so ready goes 1 exactly 2^INDEX_BITS cycles after rst_n rises. Reasserting rst_n=0 mid-INIT restarts the index at 0.
  - RUN: lookups and updates are active.
- Outputs held during reset and INIT: predict_taken=0, predict_target=0, predict_fail=0, stats=0. pcmux_sel_out follows the static fallback: F-stage B→0, JAL→3, default→{2'b0,pcmux_sel_F}. No table updates occur.
- Lookup is combinational, zero latency. predict_taken = valid & tag match & counter MSB & F-stage B-type & !killF.
- pcmux_sel_out priority, highest first:
  1. !killE & E-stage B & takenE!=predtakenE: predict_fail=1; select 5 if takenE, else 7.
  2. !killD & D-stage JALR: select 4.
  3. !killF: B-type → 6 if predict_taken, else 0; JAL → 3; JALR → 0; otherwise {2'b0,pcmux_sel_F}.
  4. killF with no higher-priority case: select 0.
- Update at the clock edge, RUN state only, when E holds an unkilled B-type:
  - Counter saturates at 0 and at 2^CNT_BITS-1; increments if takenE, decrements otherwise.
  - If takenE: write tag, target=targetE, valid=1.
  - If a tag mismatch occurs on update: reinitialise the counter to weak (taken side if takenE, else the weakly-not-taken value), then apply no further step.
- Same-index read and write in the same cycle: lookup sees the old entry (read-before-write).
- Statistics: stat_branches increments on every resolved branch; stat_mispredicts increments when predict_fail=1. Both saturate at all-ones.

Decomposition:
- Package branch_pkg: opcode constants, PCMUX_* select encodings, counter weak/strong constants, FSM state enum.
- One sub-module, bp_table: entry storage, INIT sweep, synchronous write port, asynchronous read port.
- Top level holds priority selection and statistics.

Test Plan:
- Reset, then release: ready=0 for 64 cycles and 1 on cycle 64. During INIT, a B-type at F gives sel=0 and predict_taken=0.
- Branch at pcF=0x100 resolved taken (targetE=0x80) twice: the third fetch of 0x100 gives predict_taken=1, predict_target=0x80, sel=6.
- E branch with predtakenE=1, takenE=0, pcE=0x100: predict_fail=1, sel=7, stat_mispredicts+1. Repeating with takenE=1 and predtakenE=0 gives sel=5.
- D-stage JALR with killE=1 and an F-stage B predicted taken: sel=4. With killD=1 instead: sel=6.
- Counter saturation: 5 taken updates leave the counter at 3; one not-taken update still predicts taken; a second flips the prediction.
- Aliasing: 0x100 and 0x4100 share an index. Training 0x100 taken, then fetching 0x4100 → predict_taken=0 (tag miss). Update and lookup of the same index in one cycle returns the old value.
